multicycle_shifter: RTL and testbench

MULTICYCLE_SHIFTER -- requirements
Module: multicycle_shifter

---
 rtl/multicycle_shifter.sv | 114 +++++++++++
 tb/tb_multicycle_shifter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_shifter.sv
// rtl/multicycle_shifter.sv - radix-2 multicycle shifter, one binary stage of shamt per clock
module multicycle_shifter #(
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic [WIDTH-1:0]         result,
  output logic                     ready,
  output logic                     busy,
  output logic                     done
);

  localparam int SHW = $clog2(WIDTH);
  localparam int KW  = (SHW > 1) ? $clog2(SHW) : 1;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             capture;
  logic [SHW-1:0]   shamt_q;
  logic [1:0]       mode_q;
  logic [KW-1:0]    k;
  logic [SHW:0]     amt;
  logic [WIDTH-1:0] stage_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          capture    = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (k == '0) begin
          next_state = DONE;
        end
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          capture    = 1'b1;
          next_state = SHIFT;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Stage k moves the operand by 2^k; stages run from the largest weight down.
  always_comb begin
    amt       = (SHW+1)'(1) << k;
    stage_out = result;
    case (mode_q)
      MODE_SLL: stage_out = result << amt;
      MODE_SRL: stage_out = result >> amt;
      MODE_SRA: stage_out = WIDTH'($signed(result) >>> amt);
      MODE_ROR: stage_out = (result >> amt) | (result << ((SHW+1)'(WIDTH) - amt));
      default:  stage_out = result;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result  <= '0;
      shamt_q <= '0;
      mode_q  <= '0;
      k       <= KW'(SHW-1);
    end else if (capture) begin
      result  <= data_in;
      shamt_q <= shamt;
      mode_q  <= mode;
      k       <= KW'(SHW-1);
    end else if (busy) begin
      if (shamt_q[k]) begin
        result <= stage_out;
      end
      k <= (k == '0) ? KW'(SHW-1) : k - 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_shifter.sv
// tb/tb_multicycle_shifter.sv - randomized scoreboard bench for multicycle_shifter
module tb_multicycle_shifter;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        ready;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] exp;
    int          cap;
  } exp_t;
  exp_t q[$];

  multicycle_shifter #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .mode    (mode),
    .data_in (data_in),
    .shamt   (shamt),
    .result  (result),
    .ready   (ready),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] d, input int s);
    logic [63:0] dd;
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    case (m)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return (d >> s) | (d[31] ? ~(ones >> s) : 32'h0);
      default: begin
        dd = {d, d} >> s;
        return dd[31:0];
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    if (!ready) begin
      tests++;
      fails++;
      $display("FAIL wait_ready: ready stuck at 0 after %0d cycles", n);
    end
  endtask

  task automatic issue(input logic [1:0] m, input logic [31:0] d, input logic [4:0] s, input bit push);
    exp_t e;
    wait_ready();
    mode    = m;
    data_in = d;
    shamt   = s;
    start   = 1'b1;
    if (push) begin
      e.exp = model(m, d, int'(s));
      e.cap = cyc + 1;
      q.push_back(e);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results still pending", q.size());
      q.delete();
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding operation.
  always @(negedge clock) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: done pulse with no operation pending (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        check("result", result, e.exp);
        check("latency", 32'(cyc - e.cap), 32'd5);
      end
    end
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    mode    = 2'b00;
    data_in = '0;
    shamt   = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'h0);

    issue(2'b10, 32'h8000_0000, 5'd16, 1'b1);
    drain();
    check("sra_scenario_direct", result, 32'hFFFF_8000);
    issue(2'b00, 32'h0000_0001, 5'd31, 1'b1);
    issue(2'b01, 32'hF000_0000, 5'd4, 1'b1);
    issue(2'b11, 32'h1234_5678, 5'd8, 1'b1);
    drain();
    check("ror_scenario_direct", result, 32'h7812_3456);
    for (int m = 0; m < 4; m++) issue(2'(m), 32'hA5C3_0F96, 5'd0, 1'b1);
    drain();

    issue(2'b01, 32'hDEAD_BEEF, 5'd7, 1'b1);
    tick();
    check("busy_mid_shift", 32'(busy), 32'd1);
    mode    = 2'b00;
    data_in = $urandom;
    shamt   = 5'($urandom);
    start   = 1'b1;
    tick();
    start = 1'b0;
    drain();

    // Back-to-back: start held through DONE picks up the second operand set.
    wait_ready();
    begin
      exp_t e;
      int   cap_a;
      mode    = 2'b10;
      data_in = 32'h8765_4321;
      shamt   = 5'd3;
      start   = 1'b1;
      cap_a   = cyc + 1;
      e.exp = model(2'b10, 32'h8765_4321, 3);
      e.cap = cap_a;
      q.push_back(e);
      check("b2b_ready0", 32'(ready), 32'd1);
      tick();
      mode    = 2'b11;
      data_in = 32'h0F0F_1234;
      shamt   = 5'd12;
      e.exp = model(2'b11, 32'h0F0F_1234, 12);
      e.cap = cap_a + 6;
      q.push_back(e);
      for (int i = 0; i < 5; i++) begin
        check("b2b_ready_low", 32'(ready), 32'd0);
        tick();
      end
      check("b2b_ready_done", 32'(ready), 32'd1);
      tick();
      start = 1'b0;
      check("b2b_ready_recapture", 32'(ready), 32'd0);
    end
    drain();

    // Reset lands on the third SHIFT edge of an operation that must never complete.
    issue(2'b00, 32'h1357_9BDF, 5'd9, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_result", result, 32'h0);
    repeat (8) tick();
    issue(2'b10, 32'hFFFF_FFF0, 5'd4, 1'b1);
    drain();
    check("abort_followup", result, 32'hFFFF_FFFF);

    // Start coincident with reset is dropped.
    reset   = 1'b1;
    start   = 1'b1;
    data_in = 32'h1111_1111;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("reset_start_busy", 32'(busy), 32'd0);
    check("reset_start_result", result, 32'h0);
    repeat (8) tick();

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      issue(2'($urandom), 32'($urandom), 5'($urandom), 1'b1);
    end
    drain();
    repeat (4) tick();
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
